// File: rtl/rc5_encrypt_core.sv
// rc5_encrypt_core: RC5-32/R block encryption reading the mixed S table from a synchronous RAM
module rc5_encrypt_core #(
    parameter int W        = 32,
    parameter int R        = 12,
    parameter int T        = 2*R+2,
    parameter int T_LENGTH = $clog2(T),
    parameter int ROTVALUE = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic                iS_ready,
    input  logic [W-1:0]        iA,
    input  logic [W-1:0]        iB,
    output logic [T_LENGTH-1:0] oS_address,
    input  logic [W-1:0]        iS_sub_i,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oBusy,
    output logic                oDone
);
    typedef enum logic [1:0] {IDLE, SET_ADDR, WAIT_S, APPLY} state_t;

    localparam logic [T_LENGTH-1:0] K_LAST = T_LENGTH'(T-1);

    state_t              state;
    logic [T_LENGTH-1:0] k;
    logic [W-1:0]        a, b;
    logic [W-1:0]        next_a, next_b;

    // circular left rotate: upper half of the doubled word shifted left
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROTVALUE-1:0] r);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << r;
        return dbl[2*W-1:W];
    endfunction

    // half-round datapath; k=0/1 are the plain key-whitening additions
    always_comb begin
        next_a = (k == '0) ? a + iS_sub_i : rotl(a ^ b, b[ROTVALUE-1:0]) + iS_sub_i;
        next_b = (k == T_LENGTH'(1)) ? b + iS_sub_i : rotl(b ^ a, a[ROTVALUE-1:0]) + iS_sub_i;
    end

    // control FSM: address, wait one cycle for RAM data, apply one half-round
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            a          <= '0;
            b          <= '0;
            oA         <= '0;
            oB         <= '0;
            oS_address <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart && iS_ready) begin
                        a     <= iA;
                        b     <= iB;
                        k     <= '0;
                        oBusy <= 1'b1;
                        state <= SET_ADDR;
                    end
                end
                SET_ADDR: begin
                    oS_address <= k;
                    state      <= WAIT_S;
                end
                WAIT_S: state <= APPLY;
                APPLY: begin
                    if (k[0]) b <= next_b;
                    else      a <= next_a;
                    if (k == K_LAST) begin
                        oA    <= a;
                        oB    <= next_b;
                        oDone <= 1'b1;
                        oBusy <= 1'b0;
                        k     <= '0;
                        state <= IDLE;
                    end else begin
                        k     <= k + T_LENGTH'(1);
                        state <= SET_ADDR;
                    end
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_encrypt_core.sv
// tb_rc5_encrypt_core: randomized self-checking bench against a plain RC5 reference model
module tb_rc5_encrypt_core;
    logic        clk = 1'b0, rst = 1'b0, iStart = 1'b0, iS_ready = 1'b0;
    logic [31:0] iA = '0, iB = '0, iS_sub_i, oA, oB;
    logic [4:0]  oS_address;
    logic        oBusy, oDone;
    int          checks = 0, fails = 0;
    logic [31:0] s_mem [26];
    logic [31:0] exp_a = '0, exp_b = '0;

    rc5_encrypt_core dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iS_ready(iS_ready),
        .iA(iA), .iB(iB), .oS_address(oS_address), .iS_sub_i(iS_sub_i),
        .oA(oA), .oB(oB), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 clk = ~clk;

    // synchronous S RAM with one-cycle read latency
    always @(posedge clk) iS_sub_i <= s_mem[oS_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        s = s & 31;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [63:0] rc5_ref(input logic [31:0] a, input logic [31:0] b);
        a = a + s_mem[0];
        b = b + s_mem[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl(a ^ b, int'(b[4:0])) + s_mem[2*i];
            b = rotl(b ^ a, int'(a[4:0])) + s_mem[2*i+1];
        end
        return {a, b};
    endfunction

    task automatic key_zero();
        logic [31:0] l [4];
        logic [31:0] a = '0, b = '0;
        int i = 0, j = 0;
        s_mem[0] = 32'hB7E15163;
        for (int n = 1; n < 26; n++) s_mem[n] = s_mem[n-1] + 32'h9E3779B9;
        for (int n = 0; n < 4; n++) l[n] = '0;
        for (int n = 0; n < 78; n++) begin
            a = rotl(s_mem[i] + a + b, 3);
            s_mem[i] = a;
            b = rotl(l[j] + a + b, int'(a + b));
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic wait_done(input bit poke);
        int n = 0, busy_hi = 0, addr_err = 0, hold_err = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n > 200) break;
            if (oDone) break;
            busy_hi += int'(oBusy);
            if (n >= 2 && oS_address !== 5'((n - 2) / 3)) addr_err++;
            if (oA !== exp_a || oB !== exp_b) hold_err++;
            if (poke && n == 30) begin
                iStart = 1'b1; iA = ~iA; iB = $urandom; iS_ready = 1'b0;
            end
            if (poke && n == 31) iStart = 1'b0;
        end
        iS_ready = 1'b1;
        check("latency", n, 79);
        check("busy_cycles", busy_hi, 78);
        check("addr_seq_errors", addr_err, 0);
        check("output_hold_errors", hold_err, 0);
        check("busy_at_done", {31'b0, oBusy}, 0);
        check("last_addr", {27'b0, oS_address}, 25);
    endtask

    task automatic finish_block(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] r;
        r = rc5_ref(a, b);
        wait_done(poke);
        check("oA", oA, r[63:32]);
        check("oB", oB, r[31:0]);
        exp_a = r[63:32];
        exp_b = r[31:0];
    endtask

    task automatic run_block(input logic [31:0] a, input logic [31:0] b, input bit poke, input bit hold);
        @(negedge clk);
        iA = a; iB = b; iS_ready = 1'b1; iStart = 1'b1;
        @(posedge clk);
        #1 iStart = hold;
        finish_block(a, b, poke);
        if (!hold) begin
            @(negedge clk);
            check("done_pulse_width", {31'b0, oDone}, 0);
        end
    endtask

    initial begin
        logic [31:0] a, b, addr0;
        int stale;
        for (int n = 0; n < 26; n++) s_mem[n] = '0;
        #12;
        check("rst_oA", oA, 0);
        check("rst_oB", oB, 0);
        check("rst_addr", {27'b0, oS_address}, 0);
        check("rst_busy", {31'b0, oBusy}, 0);
        check("rst_done", {31'b0, oDone}, 0);
        @(negedge clk) rst = 1'b1;

        run_block(32'h0, 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        iS_ready = 1'b0; iStart = 1'b1; iA = 32'h1234_5678; iB = 32'h9abc_def0;
        addr0 = {27'b0, oS_address};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("noready_busy", {31'b0, oBusy}, 0);
            check("noready_addr", {27'b0, oS_address}, addr0);
        end
        iS_ready = 1'b1;
        @(posedge clk);
        #1 iStart = 1'b0;
        finish_block(32'h1234_5678, 32'h9abc_def0, 1'b0);

        key_zero();
        run_block(32'h0, 32'h0, 1'b0, 1'b0);
        check("vector_oA", oA, 32'hEEDBA521);
        check("vector_oB", oB, 32'h6D8F4B15);

        a = $urandom; b = $urandom;
        run_block(a, b, 1'b1, 1'b0);

        a = $urandom; b = $urandom;
        run_block(a, b, 1'b0, 1'b1);
        a = $urandom; b = $urandom;
        iA = a; iB = b;
        @(posedge clk);
        #1 iStart = 1'b0;
        finish_block(a, b, 1'b0);

        @(negedge clk);
        iA = $urandom; iB = $urandom; iStart = 1'b1;
        @(posedge clk);
        #1 iStart = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_oA", oA, 0);
        check("arst_oB", oB, 0);
        check("arst_addr", {27'b0, oS_address}, 0);
        check("arst_busy", {31'b0, oBusy}, 0);
        check("arst_done", {31'b0, oDone}, 0);
        exp_a = '0; exp_b = '0;
        @(negedge clk) rst = 1'b1;
        stale = 0;
        repeat (100) begin
            @(negedge clk);
            stale += int'(oDone) + int'(oBusy);
        end
        check("stale_activity", stale, 0);
        run_block($urandom, $urandom, 1'b0, 1'b0);

        for (int t = 0; t < 100; t++) begin
            for (int n = 0; n < 26; n++) s_mem[n] = $urandom;
            run_block($urandom, $urandom, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
